// File: rtl/vc_state_tracker.sv
// vc_state_tracker
// Tracks ownership and credit state of each downstream virtual channel on one
// router output port. Produces the per-VC state vector read by the VC
// allocator and the per-VC credit counts read by the switch allocator.
//
// state  | meaning
// IDLE   | VC unowned, all credits home, grantable
// ACTIVE | VC owned by a packet, at least one credit available
// STALL  | VC owned by a packet, no credits available
// DRAIN  | tail sent, waiting for every credit to return
module vc_state_tracker #(
    parameter int VC_NUM    = 4,
    parameter int BUF_DEPTH = 8,
    parameter int VC_W      = 2,
    parameter int CNT_W     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [VC_NUM-1:0]         grant,
    input  logic                      send_valid,
    input  logic [VC_W-1:0]           send_vc,
    input  logic                      send_tail,
    input  logic                      credit_valid,
    input  logic [VC_W-1:0]           credit_vc,
    output logic [VC_NUM*3-1:0]       G,
    output logic [VC_NUM*CNT_W-1:0]   credits,
    output logic                      free_set0,
    output logic                      free_set1,
    output logic                      err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACTIVE = 3'd1,
        STALL  = 3'd2,
        DRAIN  = 3'd3
    } vc_state_t;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

    vc_state_t        state_q [VC_NUM];
    vc_state_t        state_d [VC_NUM];
    logic [CNT_W-1:0] cred_q  [VC_NUM];
    logic [CNT_W-1:0] cred_d  [VC_NUM];
    logic             err_q;
    logic             err_d;

    logic             grant_onehot;
    logic             grant_multi;
    logic             grant_busy;
    logic             grant_ok;
    logic             send_ok;
    logic [VC_NUM-1:0] dec;
    logic [VC_NUM-1:0] inc;
    logic [VC_NUM-1:0] ovf;

    // Classify this cycle's grant and send against the current VC states.
    always_comb begin
        grant_onehot = (grant != '0) && ((grant & (grant - 1'b1)) == '0);
        grant_multi  = (grant != '0) && !grant_onehot;
        grant_busy   = 1'b0;
        for (int i = 0; i < VC_NUM; i++) begin
            if (grant[i] && (state_q[i] != IDLE)) grant_busy = 1'b1;
        end
        grant_ok = grant_onehot && !grant_busy;
        // Only an ACTIVE VC may send; ACTIVE guarantees a credit is available.
        send_ok  = send_valid && (state_q[send_vc] == ACTIVE);
    end

    // Per-VC credit arithmetic and next-state selection.
    always_comb begin
        for (int i = 0; i < VC_NUM; i++) begin
            dec[i]     = send_ok && (send_vc == VC_W'(i));
            inc[i]     = credit_valid && (credit_vc == VC_W'(i));
            ovf[i]     = 1'b0;
            cred_d[i]  = cred_q[i];
            if (dec[i] && !inc[i]) begin
                cred_d[i] = cred_q[i] - 1'b1;
            end else if (inc[i] && !dec[i]) begin
                if (cred_q[i] == FULL) ovf[i] = 1'b1;
                else                   cred_d[i] = cred_q[i] + 1'b1;
            end

            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE: begin
                    if (grant_ok && grant[i])
                        state_d[i] = (cred_d[i] != '0) ? ACTIVE : STALL;
                end
                ACTIVE, STALL: begin
                    if (dec[i] && send_tail)  state_d[i] = DRAIN;
                    else if (cred_d[i] != '0) state_d[i] = ACTIVE;
                    else                      state_d[i] = STALL;
                end
                DRAIN: begin
                    if (cred_d[i] == FULL) state_d[i] = IDLE;
                end
                default: state_d[i] = IDLE;
            endcase
        end
        err_d = err_q | grant_multi | (grant_onehot & grant_busy)
              | (send_valid & ~send_ok) | (|ovf);
    end

    // State, credit and error registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < VC_NUM; i++) begin
                state_q[i] <= IDLE;
                cred_q[i]  <= FULL;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < VC_NUM; i++) begin
                state_q[i] <= state_d[i];
                cred_q[i]  <= cred_d[i];
            end
            err_q <= err_d;
        end
    end

    // Pack registered state onto the output buses and derive set availability.
    always_comb begin
        free_set0 = 1'b0;
        free_set1 = 1'b0;
        for (int i = 0; i < VC_NUM; i++) begin
            G[3*i +: 3]              = state_q[i];
            credits[CNT_W*i +: CNT_W] = cred_q[i];
            if (state_q[i] == IDLE) begin
                if (i < VC_NUM/2) free_set0 = 1'b1;
                else              free_set1 = 1'b1;
            end
        end
        err = err_q;
    end

endmodule

// File: tb/tb_vc_state_tracker.sv
// Bench for vc_state_tracker: directed walk through the main scenarios plus a
// randomized run, every cycle compared against a packet-level reference model.
module tb_vc_state_tracker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  grant = '0;
    logic        send_valid = 1'b0;
    logic [1:0]  send_vc = '0;
    logic        send_tail = 1'b0;
    logic        credit_valid = 1'b0;
    logic [1:0]  credit_vc = '0;
    logic [11:0] g_out;
    logic [15:0] credits;
    logic        free_set0;
    logic        free_set1;
    logic        err;

    int total = 0;
    int bad   = 0;

    // reference model: ownership, drain flag and credit count per VC
    int m_cred [4];
    bit m_own  [4];
    bit m_drn  [4];
    bit m_err;

    vc_state_tracker #(.VC_NUM(4), .BUF_DEPTH(8), .VC_W(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .grant(grant),
        .send_valid(send_valid), .send_vc(send_vc), .send_tail(send_tail),
        .credit_valid(credit_valid), .credit_vc(credit_vc),
        .G(g_out), .credits(credits),
        .free_set0(free_set0), .free_set1(free_set1), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] m_code(int v);
        if (!m_own[v])     return 3'd0;
        if (m_drn[v])      return 3'd3;
        if (m_cred[v] > 0) return 3'd1;
        return 3'd2;
    endfunction

    task automatic model_step();
        int  take;
        int  c;
        bit  ok_send;
        if (rst) begin
            for (int v = 0; v < 4; v++) begin
                m_own[v] = 0; m_drn[v] = 0; m_cred[v] = 8;
            end
            m_err = 0;
        end else begin
            take = -1;
            if ($countones(grant) > 1) m_err = 1;
            else if ($countones(grant) == 1) begin
                for (int v = 0; v < 4; v++)
                    if (grant[v]) begin
                        if (m_own[v]) m_err = 1;
                        else          take = v;
                    end
            end
            ok_send = send_valid && m_own[send_vc] && !m_drn[send_vc] && (m_cred[send_vc] > 0);
            if (send_valid && !ok_send) m_err = 1;
            for (int v = 0; v < 4; v++) begin
                c = m_cred[v];
                if (ok_send && send_vc == v) c--;
                if (credit_valid && credit_vc == v) begin
                    if (c == 8) m_err = 1;
                    else        c++;
                end
                if (v == take) begin
                    m_own[v] = 1; m_drn[v] = 0;
                end else if (ok_send && send_vc == v && send_tail) begin
                    m_drn[v] = 1;
                end else if (m_drn[v] && c == 8) begin
                    m_own[v] = 0; m_drn[v] = 0;
                end
                m_cred[v] = c;
            end
        end
    endtask

    task automatic check_all();
        logic [11:0] eg;
        logic [15:0] ec;
        for (int v = 0; v < 4; v++) begin
            eg[3*v +: 3] = m_code(v);
            ec[4*v +: 4] = 4'(m_cred[v]);
        end
        chk("G", 32'(g_out), 32'(eg));
        chk("credits", 32'(credits), 32'(ec));
        chk("err", 32'(err), 32'(m_err));
        chk("free_set0", 32'(free_set0), 32'(!m_own[0] || !m_own[1]));
        chk("free_set1", 32'(free_set1), 32'(!m_own[2] || !m_own[3]));
    endtask

    task automatic drive(input logic r, input logic [3:0] gr,
                         input logic sv, input logic [1:0] svc, input logic st,
                         input logic cv, input logic [1:0] cvc);
        rst = r; grant = gr;
        send_valid = sv; send_vc = svc; send_tail = st;
        credit_valid = cv; credit_vc = cvc;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_cyc();       drive(0, 4'b0, 0, 2'd0, 0, 0, 2'd0); endtask
    task automatic do_rst();         drive(1, 4'b0, 0, 2'd0, 0, 0, 2'd0); endtask
    task automatic do_grant(input logic [3:0] gr) ; drive(0, gr, 0, 2'd0, 0, 0, 2'd0); endtask
    task automatic do_send(input logic [1:0] vc, input logic tl); drive(0, 4'b0, 1, vc, tl, 0, 2'd0); endtask
    task automatic do_credit(input logic [1:0] vc); drive(0, 4'b0, 0, 2'd0, 0, 1, vc); endtask

    initial begin
        logic [3:0] gr;
        logic       sv, st, cv;
        logic [1:0] svc, cvc;
        int         pick;

        // reset state
        do_rst();
        chk("rst_G", 32'(g_out), 32'h0);
        chk("rst_credits", 32'(credits), 32'h8888);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_free", 32'({free_set1, free_set0}), 32'h3);

        // VC1: grant, three sends, three credits back
        do_grant(4'b0010);
        for (int i = 0; i < 3; i++) do_send(2'd1, 0);
        chk("vc1_state", 32'(g_out[5:3]), 32'd1);
        chk("vc1_cred5", 32'(credits[7:4]), 32'd5);
        for (int i = 0; i < 3; i++) do_credit(2'd1);
        chk("vc1_cred8", 32'(credits[7:4]), 32'd8);
        chk("vc1_active", 32'(g_out[5:3]), 32'd1);

        // VC0: exhaust credits, then an illegal send in STALL
        do_grant(4'b0001);
        for (int i = 0; i < 8; i++) do_send(2'd0, 0);
        chk("vc0_stall", 32'(g_out[2:0]), 32'd2);
        chk("vc0_cred0", 32'(credits[3:0]), 32'd0);
        chk("vc0_err0", 32'(err), 32'd0);
        do_send(2'd0, 0);
        chk("vc0_err1", 32'(err), 32'd1);
        chk("vc0_cred_hold", 32'(credits[3:0]), 32'd0);
        do_credit(2'd0);
        chk("vc0_reactive", 32'(g_out[2:0]), 32'd1);

        // VC2 tail and drain, while VC3 holds the other set-1 VC
        do_rst();
        do_grant(4'b1000);
        do_grant(4'b0100);
        do_send(2'd2, 1);
        chk("vc2_drain", 32'(g_out[8:6]), 32'd3);
        chk("vc2_cred7", 32'(credits[11:8]), 32'd7);
        chk("set1_busy", 32'(free_set1), 32'd0);
        do_credit(2'd2);
        chk("vc2_idle", 32'(g_out[8:6]), 32'd0);
        chk("set1_free", 32'(free_set1), 32'd1);
        do_grant(4'b0100);
        chk("vc2_regrant", 32'(g_out[8:6]), 32'd1);

        // VC3: simultaneous send and credit, then a grant to a busy VC
        for (int i = 0; i < 4; i++) do_send(2'd3, 0);
        drive(0, 4'b0, 1, 2'd3, 0, 1, 2'd3);
        chk("vc3_cred4", 32'(credits[15:12]), 32'd4);
        chk("vc3_active", 32'(g_out[11:9]), 32'd1);
        chk("vc3_err0", 32'(err), 32'd0);
        do_grant(4'b1000);
        chk("busy_grant_err", 32'(err), 32'd1);

        // multi-hot grant and credit overflow
        do_rst();
        do_grant(4'b0011);
        chk("multi_grant_err", 32'(err), 32'd1);
        chk("multi_grant_G", 32'(g_out), 32'd0);
        do_rst();
        do_credit(2'd0);
        chk("ovf_cred", 32'(credits[3:0]), 32'd8);
        chk("ovf_err", 32'(err), 32'd1);

        // tail on the last credit: DRAIN at 0 until all eight return
        do_rst();
        do_grant(4'b0001);
        for (int i = 0; i < 7; i++) do_send(2'd0, 0);
        do_send(2'd0, 1);
        chk("tail_c0_drain", 32'(g_out[2:0]), 32'd3);
        for (int i = 0; i < 7; i++) do_credit(2'd0);
        chk("tail_c0_still", 32'(g_out[2:0]), 32'd3);
        do_credit(2'd0);
        chk("tail_c0_idle", 32'(g_out[2:0]), 32'd0);

        // randomized traffic, mostly legal
        do_rst();
        for (int n = 0; n < 3000; n++) begin
            gr = '0;
            pick = int'($urandom_range(0, 31));
            if (pick < 6)       gr = 4'(1 << $urandom_range(0, 3));
            else if (pick == 6) gr = 4'($urandom);

            sv  = ($urandom_range(0, 1) == 1);
            svc = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                for (int k = 0; k < 4; k++)
                    if (m_own[(int'(svc) + k) % 4] && !m_drn[(int'(svc) + k) % 4]
                        && m_cred[(int'(svc) + k) % 4] > 0) begin
                        svc = 2'((int'(svc) + k) % 4);
                        break;
                    end
            end
            st  = ($urandom_range(0, 5) == 0);

            cvc = 2'($urandom_range(0, 3));
            cv  = ($urandom_range(0, 1) == 1);
            if (cv && m_cred[cvc] == 8 && $urandom_range(0, 15) != 0) cv = 0;

            drive(($urandom_range(0, 59) == 0), gr, sv, svc, st, cv, cvc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vc_state_tracker.md
# vc_state_tracker

Per-output-port tracker of downstream virtual-channel ownership and credits for the 3D-torus router. Each output port (xpos, ypos, zpos, xneg, yneg, zneg) instantiates one copy. It consumes VC grants, flit departures and returned credits. It produces the registered 3-bit-per-VC global state vector (G_*) that the VC allocator reads, plus per-VC credit counts for the switch allocator.

## Interface
Parameters:
- VC_NUM, 4, VCs per physical port (two dateline sets of VC_NUM/2; set 0 = VCs [VC_NUM/2-1:0], set 1 = upper half)
- BUF_DEPTH, 8, downstream input-buffer depth per VC (flits) = initial credits
- VC_W, 2, clog2(VC_NUM)
- CNT_W, 4, clog2(BUF_DEPTH+1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- grant  in  VC_NUM  one-hot VC grant from VC allocator for this output port (all-zero = none)
- send_valid  in  1  a flit leaves this output port this cycle
- send_vc  in  VC_W  downstream VC of departing flit
- send_tail  in  1  departing flit is a tail (single-flit packets assert head and tail; tail is all that matters here)
- credit_valid  in  1  downstream returns one credit
- credit_vc  in  VC_W  VC of returned credit
- G  out  VC_NUM*3  per-VC state, VC i at [3i+2:3i], registered
- credits  out  VC_NUM*CNT_W  per-VC credit count, VC i at [CNT_W*i+CNT_W-1:CNT_W*i], registered
- free_set0  out  1  at least one VC of set 0 is IDLE (registered-derived, combinational from G)
- free_set1  out  1  same for set 1
- err  out  1  sticky protocol-violation flag, cleared only by rst

## Operation
- State encoding per VC: IDLE=3'd0, ACTIVE=3'd1 (owned, credits>0), STALL=3'd2 (owned, credits==0), DRAIN=3'd3 (tail sent, waiting for all credits back). Codes 4-7 unused; never produced.
- Transitions per VC (evaluated from current state, next-cycle credit count c'):
  - IDLE + grant bit -> ACTIVE (or STALL if c'==0; cannot occur after legal drain)
  - ACTIVE/STALL + send on this VC with send_tail -> DRAIN
  - ACTIVE/STALL otherwise -> ACTIVE if c'>0 else STALL
  - DRAIN + c'==BUF_DEPTH -> IDLE; else stay DRAIN
- Credit arithmetic per VC: c' = c - send + credit. Send and credit on same VC same cycle -> c unchanged.
- Legal send requires state ACTIVE (STALL/IDLE/DRAIN send is illegal). Illegal send: ignored (no decrement, no state change), err<=1.
- Grant to non-IDLE VC, or grant not one-hot: entire grant ignored, err<=1.
- Credit return making c exceed BUF_DEPTH: count saturates at BUF_DEPTH, err<=1.
- Independent VCs update in parallel; one send and one credit per cycle max by construction of inputs.

## Timing
- Reset (rst high at edge): every VC G=IDLE, credits=BUF_DEPTH, err=0; free_set0=free_set1=1 one cycle later is not needed: they follow G combinationally.
- All inputs sampled at edge t; G/credits/err reflect them after edge t (1-cycle latency).
- A VC freed (DRAIN->IDLE) at edge t is grantable by a grant presented in cycle t+1's sampling edge.
- Last-credit send: ACTIVE with c=1 + send (no tail) -> STALL next cycle; credit return in STALL -> ACTIVE next cycle.
- Tail with c=1: DRAIN with c=0; stays DRAIN until BUF_DEPTH credits returned.
- rst asserted mid-packet: all VCs forced IDLE/full credits regardless of other inputs that cycle.

## Test plan
- Reset: rst 1 cycle -> G=0, every credit field=8, err=0, free_set0=free_set1=1.
- Grant 4'b0010, then 3 sends on VC1 (no tail) -> G[5:3]=1, credits VC1=5; 3 credit returns -> 8, still ACTIVE.
- Grant VC0, 8 sends -> STALL with credits 0 after 8th send; 9th send -> ignored, err=1, credits stay 0.
- Grant VC2, send one flit with tail -> DRAIN, credits 7; simultaneous send+credit cycles absent; one credit return -> IDLE next edge, free_set1=1.
- Same-cycle send and credit on ACTIVE VC3 with credits 4 -> credits stay 4, state ACTIVE; grant to VC3 while ACTIVE -> ignored, err=1.
- Grant 4'b0011 -> ignored, err=1; credit to IDLE VC with 8 credits -> stays 8, err=1.
